// File: rtl/mips_pkg.sv
// Shared MIPS decode constants and the IF/ID next-state action type.
package mips_pkg;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;
    localparam logic [4:0]  REG_ZERO  = 5'd0;

    localparam int RS_HI  = 25;
    localparam int RS_LO  = 21;
    localparam int RT_HI  = 20;
    localparam int RT_LO  = 16;
    localparam int RD_HI  = 15;
    localparam int RD_LO  = 11;
    localparam int IMM_HI = 15;
    localparam int IMM_LO = 0;

    typedef enum logic [1:0] {
        ACT_LOAD  = 2'd0,
        ACT_HOLD  = 2'd1,
        ACT_FLUSH = 2'd2
    } ifid_action_t;

    function automatic logic [31:0] sign_extend16(input logic [15:0] imm);
        return {{16{imm[15]}}, imm};
    endfunction

endpackage

// File: rtl/hazard_detect.sv
// Load-use hazard comparator: a valid ID instruction reading the register an in-flight load writes.
module hazard_detect
    import mips_pkg::*;
(
    input  logic       ID_EX_MemRead,
    input  logic [4:0] ID_EX_rt,
    input  logic [4:0] rs,
    input  logic [4:0] rt,
    input  logic       valid,
    output logic       stall
);

    logic w_rt_nonzero;
    logic w_src_match;

    // $0 is hard-wired, so a load targeting it can never create a real dependency.
    assign w_rt_nonzero = (ID_EX_rt != REG_ZERO);
    assign w_src_match  = (ID_EX_rt == rs) || (ID_EX_rt == rt);
    assign stall        = valid && ID_EX_MemRead && w_rt_nonzero && w_src_match;

endmodule

// File: rtl/if_id_stage.sv
// IF/ID pipeline register with field decode, load-use stall, branch flush and saturating event counters.
module if_id_stage #(
    parameter int STALL_CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [31:0]            PC_plus4_in,
    input  logic [31:0]            Instr_in,
    input  logic                   ID_EX_MemRead,
    input  logic [4:0]             ID_EX_rt,
    input  logic                   Branch_taken,
    output logic [31:0]            PC_plus4_out,
    output logic [31:0]            Instr_out,
    output logic [4:0]             rs_out,
    output logic [4:0]             rt_out,
    output logic [4:0]             rd_out,
    output logic [31:0]            sign_ext_out,
    output logic                   valid_out,
    output logic                   PCWrite,
    output logic                   ctrl_bubble,
    output logic [STALL_CNT_W-1:0] stall_cnt,
    output logic [STALL_CNT_W-1:0] flush_cnt
);
    import mips_pkg::*;

    logic [31:0]            r_instr;
    logic [31:0]            r_pc_plus4;
    logic                   r_valid;
    logic [STALL_CNT_W-1:0] r_stall_cnt;
    logic [STALL_CNT_W-1:0] r_flush_cnt;

    logic                   w_stall;
    ifid_action_t           w_action;

    hazard_detect u_hazard_detect (
        .ID_EX_MemRead (ID_EX_MemRead),
        .ID_EX_rt      (ID_EX_rt),
        .rs            (r_instr[RS_HI:RS_LO]),
        .rt            (r_instr[RT_HI:RT_LO]),
        .valid         (r_valid),
        .stall         (w_stall)
    );

    // A taken branch makes the fetched word wrong-path, so it beats a pending stall.
    always_comb begin
        w_action = ACT_LOAD;
        if (Branch_taken) begin
            w_action = ACT_FLUSH;
        end else if (w_stall) begin
            w_action = ACT_HOLD;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_instr    <= NOP_INSTR;
            r_pc_plus4 <= 32'h0;
            r_valid    <= 1'b0;
        end else begin
            case (w_action)
                ACT_FLUSH: begin
                    r_instr    <= NOP_INSTR;
                    r_pc_plus4 <= PC_plus4_in;
                    r_valid    <= 1'b0;
                end
                ACT_LOAD: begin
                    r_instr    <= Instr_in;
                    r_pc_plus4 <= PC_plus4_in;
                    r_valid    <= 1'b1;
                end
                default: begin
                    r_instr    <= r_instr;
                    r_pc_plus4 <= r_pc_plus4;
                    r_valid    <= r_valid;
                end
            endcase
        end
    end

    // Counters stick at all-ones so long runs never read back as small values.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            if ((w_action == ACT_HOLD) && (r_stall_cnt != '1)) begin
                r_stall_cnt <= r_stall_cnt + STALL_CNT_W'(1);
            end
            if ((w_action == ACT_FLUSH) && (r_flush_cnt != '1)) begin
                r_flush_cnt <= r_flush_cnt + STALL_CNT_W'(1);
            end
        end
    end

    assign Instr_out    = r_instr;
    assign PC_plus4_out = r_pc_plus4;
    assign valid_out    = r_valid;
    assign stall_cnt    = r_stall_cnt;
    assign flush_cnt    = r_flush_cnt;

    assign rs_out       = r_instr[RS_HI:RS_LO];
    assign rt_out       = r_instr[RT_HI:RT_LO];
    assign rd_out       = r_instr[RD_HI:RD_LO];
    assign sign_ext_out = sign_extend16(r_instr[IMM_HI:IMM_LO]);

    assign PCWrite      = ~w_stall | Branch_taken;
    assign ctrl_bubble  = w_stall | ~r_valid;

endmodule
